dual_lane_memory_access: RTL and testbench

Memory-stage access unit for the dual-issue pipeline, directly downstream of the execute-to-memory pipeline register. It takes both lanes' M-stage controls (`ResultSrcM*`, `MemWriteM*`, `AddressingControlM*`), address (`ALUResultM*`) and store data (`WriteDataM*`), and serialises them onto the single-port data memory. When both lanes access memory in the same cycle, it stalls the pipeline for one cycle. It produces aligned, sign- or zero-extended load data for both lanes, ready for the memory-to-writeback register.

---
 rtl/dual_lane_memory_access_if.sv | 29 ++
 rtl/dual_lane_memory_access.sv | 79 +++++++
 tb/tb_dual_lane_memory_access.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dual_lane_memory_access_if.sv
// dual_lane_memory_access_if: M-stage lane controls plus single-port data-memory bus
interface dual_lane_memory_access_if #(parameter int ADDR_WIDTH = 32);
  logic                  MemWriteM1, MemWriteM2;
  logic [1:0]            ResultSrcM1, ResultSrcM2;
  logic [2:0]            AddressingControlM1, AddressingControlM2;
  logic [ADDR_WIDTH-1:0] ALUResultM1, ALUResultM2;
  logic [31:0]           WriteDataM1, WriteDataM2;
  logic [ADDR_WIDTH-1:0] DMemAddr;
  logic [31:0]           DMemWData;
  logic [3:0]            DMemByteEn;
  logic                  DMemWE;
  logic [31:0]           DMemRData;
  logic [31:0]           ReadDataM1, ReadDataM2;
  logic                  StallM, MisalignM1, MisalignM2;
  modport master (
    output MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2,
           AddressingControlM1, AddressingControlM2, ALUResultM1, ALUResultM2,
           WriteDataM1, WriteDataM2, DMemRData,
    input  DMemAddr, DMemWData, DMemByteEn, DMemWE,
           ReadDataM1, ReadDataM2, StallM, MisalignM1, MisalignM2
  );
  modport slave (
    input  MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2,
           AddressingControlM1, AddressingControlM2, ALUResultM1, ALUResultM2,
           WriteDataM1, WriteDataM2, DMemRData,
    output DMemAddr, DMemWData, DMemByteEn, DMemWE,
           ReadDataM1, ReadDataM2, StallM, MisalignM1, MisalignM2
  );
endinterface

// File: rtl/dual_lane_memory_access.sv
// dual_lane_memory_access: serialises two M-stage lanes onto one data-memory port,
// lane 1 first, stalling one cycle when both lanes access memory.
module dual_lane_memory_access #(parameter int ADDR_WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  dual_lane_memory_access_if.slave bus
);
  typedef enum logic {IDLE, SECOND} state_t;
  state_t r_state, w_next;
  logic [31:0] r_held1;
  logic w_ld1, w_ld2, w_st1, w_st2, w_mis1, w_mis2, w_act1, w_act2, w_both;
  logic w_sel2, w_serve, w_ld, w_st, w_b, w_h;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0] w_ac;
  logic [31:0] w_wd, w_rd, w_bsh;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // unknown encodings fall through to word alignment
  function automatic logic misal(input logic [2:0] ac, input logic [1:0] a);
    return (ac == 3'b000 || ac == 3'b100) ? 1'b0 :
           (ac == 3'b001 || ac == 3'b101) ? a[0] : |a;
  endfunction

  assign w_ld1  = bus.ResultSrcM1 == 2'b01;
  assign w_ld2  = bus.ResultSrcM2 == 2'b01;
  assign w_st1  = bus.MemWriteM1;
  assign w_st2  = bus.MemWriteM2;
  assign w_mis1 = (w_st1 | w_ld1) & misal(bus.AddressingControlM1, bus.ALUResultM1[1:0]);
  assign w_mis2 = (w_st2 | w_ld2) & misal(bus.AddressingControlM2, bus.ALUResultM2[1:0]);
  assign w_act1 = (w_st1 | w_ld1) & ~w_mis1;
  assign w_act2 = (w_st2 | w_ld2) & ~w_mis2;
  assign w_both = w_act1 & w_act2;

  assign w_sel2  = (r_state == SECOND) | (w_act2 & ~w_act1);
  assign w_serve = w_sel2 ? w_act2 : w_act1;
  assign w_addr  = w_sel2 ? bus.ALUResultM2 : bus.ALUResultM1;
  assign w_ac    = w_sel2 ? bus.AddressingControlM2 : bus.AddressingControlM1;
  assign w_wd    = w_sel2 ? bus.WriteDataM2 : bus.WriteDataM1;
  assign w_ld    = w_serve & (w_sel2 ? w_ld2 : w_ld1);
  assign w_st    = w_serve & (w_sel2 ? w_st2 : w_st1);
  assign w_b     = w_ac == 3'b000 || w_ac == 3'b100;
  assign w_h     = w_ac == 3'b001 || w_ac == 3'b101;

  assign w_bsh  = bus.DMemRData >> {w_addr[1:0], 3'b000};
  assign w_byte = w_bsh[7:0];
  assign w_half = w_addr[1] ? bus.DMemRData[31:16] : bus.DMemRData[15:0];
  assign w_rd   = !w_ld              ? '0 :
                  w_ac == 3'b000     ? {{24{w_byte[7]}}, w_byte} :
                  w_ac == 3'b100     ? {24'b0, w_byte} :
                  w_ac == 3'b001     ? {{16{w_half[15]}}, w_half} :
                  w_ac == 3'b101     ? {16'b0, w_half} : bus.DMemRData;

  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE && w_both) w_next = SECOND;
  end

  assign bus.StallM     = rst_n & (r_state == IDLE) & w_both;
  assign bus.DMemWE     = rst_n & w_st;
  assign bus.DMemAddr   = w_serve ? {w_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.DMemByteEn = !(rst_n && w_st) ? 4'b0000 :
                          w_b ? 4'b0001 << w_addr[1:0] :
                          w_h ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bus.DMemWData  = !w_st ? '0 : w_b ? {4{w_wd[7:0]}} : w_h ? {2{w_wd[15:0]}} : w_wd;
  assign bus.ReadDataM1 = !rst_n ? '0 : r_state == SECOND ? r_held1 : w_sel2 ? '0 : w_rd;
  assign bus.ReadDataM2 = (rst_n && w_sel2) ? w_rd : '0;
  assign bus.MisalignM1 = rst_n & w_mis1;
  assign bus.MisalignM2 = rst_n & w_mis2;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_held1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_both) r_held1 <= w_rd;
    end
endmodule

// File: tb/tb_dual_lane_memory_access.sv
// tb_dual_lane_memory_access: directed plus random lane pairs checked against a
// byte-array program-order model of the data memory.
module tb_dual_lane_memory_access;
  typedef struct packed {
    logic st; logic ld; logic [2:0] ac; logic [31:0] a; logic [31:0] wd;
  } op_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_lane_memory_access_if #(.ADDR_WIDTH(32)) bus();
  dual_lane_memory_access #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:1023];
  logic [7:0]  rmem [0:4095];
  logic        poke_en = 1'b0, clr = 1'b0;
  logic [31:0] poke_a = '0, poke_d = '0;
  int n_pass = 0, n_chk = 0, n_fail = 0;
  op_t none_op;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  assign bus.DMemRData = mem[bus.DMemAddr[11:2]];
  always @(posedge clk)
    if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (poke_en) mem[poke_a[11:2]] <= poke_d;
    else if (bus.DMemWE) mem[bus.DMemAddr[11:2]] <= merge(mem[bus.DMemAddr[11:2]], bus.DMemWData, bus.DMemByteEn);

  function automatic op_t mk(input logic st, input logic ld, input logic [2:0] ac, input logic [31:0] a, input logic [31:0] wd);
    return '{st: st, ld: ld, ac: ac, a: a, wd: wd};
  endfunction
  function automatic int size(input logic [2:0] ac);
    return (ac == 3'd0 || ac == 3'd4) ? 1 : (ac == 3'd1 || ac == 3'd5) ? 2 : 4;
  endfunction
  function automatic bit mis(input op_t o);
    return (o.st || o.ld) && (o.a % size(o.ac)) != 0;
  endfunction
  function automatic bit act(input op_t o);
    return (o.st || o.ld) && !mis(o);
  endfunction
  function automatic logic [31:0] ref_load(input op_t o);
    logic [31:0] v = '0;
    int sz = size(o.ac);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[int'(o.a[11:0]) + i];
    if (o.ac == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (o.ac == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'(a[11:0]) & ~3;
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction
  task automatic ref_store(input op_t o);
    for (int i = 0; i < size(o.ac); i++) rmem[int'(o.a[11:0]) + i] = o.wd[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input op_t o1, input op_t o2);
    bus.MemWriteM1 = o1.st; bus.ResultSrcM1 = o1.ld ? 2'b01 : 2'b10;
    bus.AddressingControlM1 = o1.ac; bus.ALUResultM1 = o1.a; bus.WriteDataM1 = o1.wd;
    bus.MemWriteM2 = o2.st; bus.ResultSrcM2 = o2.ld ? 2'b01 : 2'b00;
    bus.AddressingControlM2 = o2.ac; bus.ALUResultM2 = o2.a; bus.WriteDataM2 = o2.wd;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(none_op, none_op);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    for (int i = 0; i < 4; i++) rmem[(int'(a[11:0]) & ~3) + i] = d[8*i +: 8];
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic chk_serve(input string tag, input op_t f, input bit any);
    bit we = any && f.st;
    int sz = size(f.ac);
    logic [3:0] be = we ? 4'(((1 << sz) - 1) << f.a[1:0]) : 4'b0;
    logic [31:0] wd = sz == 1 ? {4{f.wd[7:0]}} : sz == 2 ? {2{f.wd[15:0]}} : f.wd;
    chk({tag, "_addr"}, bus.DMemAddr, any ? f.a & ~32'd3 : 32'd0);
    chk({tag, "_we"}, 32'(bus.DMemWE), 32'(we));
    chk({tag, "_be"}, 32'(bus.DMemByteEn), 32'(be));
    if (we) chk({tag, "_wdata"}, bus.DMemWData, wd);
  endtask

  task automatic run(input op_t o1, input op_t o2);
    bit a1 = act(o1), a2 = act(o2);
    logic [31:0] e1, e2;
    e1 = (a1 && o1.ld) ? ref_load(o1) : '0;
    if (a1 && o1.st) ref_store(o1);
    e2 = (a2 && o2.ld) ? ref_load(o2) : '0;
    if (a2 && o2.st) ref_store(o2);
    @(negedge clk);
    drive(o1, o2);
    #2;
    chk("mis1", 32'(bus.MisalignM1), 32'(mis(o1)));
    chk("mis2", 32'(bus.MisalignM2), 32'(mis(o2)));
    chk("stall_c0", 32'(bus.StallM), 32'(a1 && a2));
    chk_serve("c0", a1 ? o1 : o2, a1 || a2);
    chk("rd1_c0", bus.ReadDataM1, e1);
    chk("rd2_c0", bus.ReadDataM2, (a1 && a2) ? 32'd0 : e2);
    if (a1 && a2) begin
      @(negedge clk);
      #2;
      chk("stall_c1", 32'(bus.StallM), 32'd0);
      chk_serve("c1", o2, 1'b1);
      chk("rd1_c1", bus.ReadDataM1, e1);
      chk("rd2_c1", bus.ReadDataM2, e2);
    end
    @(negedge clk);
    drive(none_op, none_op);
  endtask

  initial begin
    op_t o1, o2;
    logic [2:0] acs [0:7];
    none_op = mk(0, 0, 3'd2, 32'd0, 32'd0);
    acs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd2};
    for (int i = 0; i < 4096; i++) rmem[i] = 8'h00;
    // outputs forced low while reset is held, even with live misaligned/dual requests
    drive(mk(1, 0, 3'd2, 32'h102, 32'h1), mk(0, 1, 3'd2, 32'h104, 32'h0));
    clr = 1'b1;
    @(negedge clk); @(negedge clk);
    clr = 1'b0;
    #2;
    chk("rst_stall", 32'(bus.StallM), 32'd0);
    chk("rst_we", 32'(bus.DMemWE), 32'd0);
    chk("rst_be", 32'(bus.DMemByteEn), 32'd0);
    chk("rst_rd1", bus.ReadDataM1, 32'd0);
    chk("rst_rd2", bus.ReadDataM2, 32'd0);
    chk("rst_mis1", 32'(bus.MisalignM1), 32'd0);
    drive(none_op, none_op);
    @(negedge clk);
    rst_n = 1'b1;

    run(mk(1, 0, 3'd2, 32'h100, 32'hDEADBEEF), none_op);
    poke(32'h100, 32'h80FF0000);
    run(none_op, mk(0, 1, 3'd0, 32'h103, 32'h0));
    run(none_op, mk(0, 1, 3'd4, 32'h103, 32'h0));
    poke(32'h200, 32'h11111111);
    poke(32'h204, 32'h80001234);
    run(mk(0, 1, 3'd2, 32'h200, 32'h0), mk(0, 1, 3'd1, 32'h206, 32'h0));
    poke(32'h300, 32'h0);
    run(mk(1, 0, 3'd0, 32'h300, 32'h000000AB), mk(0, 1, 3'd4, 32'h300, 32'h0));
    run(mk(1, 0, 3'd2, 32'h102, 32'h55), mk(0, 1, 3'd2, 32'h400, 32'h0));
    run(mk(0, 1, 3'd3, 32'h101, 32'h0), mk(1, 0, 3'd5, 32'h402, 32'hBEEF));
    run(mk(0, 0, 3'd1, 32'h1, 32'h0), none_op);

    // reset during the second cycle: lane 1's store has landed, lane 2's must not
    o1 = mk(1, 0, 3'd2, 32'h500, 32'h12345678);
    o2 = mk(1, 0, 3'd2, 32'h504, 32'hCAFEF00D);
    @(negedge clk);
    drive(o1, o2);
    #2;
    chk("mid_stall_c0", 32'(bus.StallM), 32'd1);
    ref_store(o1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_stall", 32'(bus.StallM), 32'd0);
    chk("mid_we", 32'(bus.DMemWE), 32'd0);
    chk("mid_rd1", bus.ReadDataM1, 32'd0);
    @(negedge clk);
    drive(none_op, none_op);
    rst_n = 1'b1;
    chk("mid_mem1", mem[32'h500 >> 2], ref_word(32'h500));
    chk("mid_mem2", mem[32'h504 >> 2], ref_word(32'h504));
    run(mk(0, 1, 3'd2, 32'h500, 32'h0), mk(0, 1, 3'd2, 32'h504, 32'h0));

    for (int n = 0; n < 120; n++) begin
      for (int l = 0; l < 2; l++) begin
        op_t o;
        int k = $urandom_range(0, 2);
        o = mk(k == 2, k == 1, acs[$urandom_range(0, 7)], 32'($urandom_range(0, 4095)), $urandom);
        if ($urandom_range(0, 3) != 0) o.a = o.a & ~32'(size(o.ac) - 1);
        if (l == 0) o1 = o;
        else o2 = o;
      end
      if ($urandom_range(0, 3) == 0) o2.a = o1.a;
      run(o1, o2);
    end
    for (int w = 0; w < 1024; w += 97) chk("final_mem", mem[w], ref_word(32'(w * 4)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
